// File: rtl/resv_dispatch_arb.sv
// Dispatch arbiter between decode and the reservation stations: a one-entry packet
// buffer, round-robin selection of an eligible RS, flush sequencing and a blocked-cycle counter.
module resv_dispatch_arb #(
    parameter int                N_RS          = 4,
    parameter int                W_RS_IDX      = 2,
    parameter int                W_PD_UOPS     = 6,
    parameter int                W_PKT         = 150,
    parameter logic [8*N_RS-1:0] RS_CLASS_MASK = {N_RS{8'hFF}},
    parameter int                FLUSH_CYC     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_PKT-1:0]  DFI_PD_pkt,
    input  logic              CFI_PC_vld,
    output logic              CFO_PC_rdy,
    input  logic [N_RS-1:0]   CFI_PC_full,
    input  logic              CFI_PC_flush,
    output logic [W_PKT-1:0]  DFO_PD_pkt,
    output logic [N_RS-1:0]   CFO_PC_ena,
    output logic              CFO_PC_clear,
    output logic              CFO_PC_err,
    output logic [15:0]       CDO_PD_blkcnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_r;
    logic [W_PKT-1:0]    buf_pkt_r;
    logic [W_RS_IDX-1:0] rr_ptr_r;
    logic [15:0]         blkcnt_r;
    logic [3:0]          flush_cnt_r;

    logic [2:0]          cls_s;
    logic [N_RS-1:0]     route_s;
    logic [N_RS-1:0]     elig_s;
    logic [W_RS_IDX-1:0] sel_s;
    logic                found_s;
    logic                dispatch_s;
    logic                drop_s;
    logic                blocked_s;

    // Class lookup and eligibility of each RS for the buffered packet
    always_comb begin
        cls_s   = buf_pkt_r[W_PD_UOPS-1 -: 3];
        route_s = '0;
        elig_s  = '0;
        for (int k = 0; k < N_RS; k++) begin
            route_s[k] = RS_CLASS_MASK[8*k + int'(cls_s)];
            elig_s[k]  = route_s[k] & ~CFI_PC_full[k];
        end
    end

    // Round-robin search starting at rr_ptr_r, first eligible RS wins
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N_RS; i++) begin
            if (!found_s && elig_s[(int'(rr_ptr_r) + i) % N_RS]) begin
                found_s = 1'b1;
                sel_s   = W_RS_IDX'((int'(rr_ptr_r) + i) % N_RS);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Buffer disposition and handshake outputs; flush overrides everything
    always_comb begin
        dispatch_s   = (state_r == ST_FULL) && found_s;
        drop_s       = (state_r == ST_FULL) && (route_s == '0);
        blocked_s    = (state_r == ST_FULL) && (route_s != '0) && !found_s;
        CFO_PC_rdy   = !CFI_PC_flush && ((state_r == ST_EMPTY) || dispatch_s || drop_s);
        CFO_PC_err   = !CFI_PC_flush && drop_s;
        CFO_PC_clear = (state_r == ST_FLUSH);
        if (dispatch_s && !CFI_PC_flush) begin
            CFO_PC_ena = N_RS'(1) << sel_s;
        end else begin
            CFO_PC_ena = '0;
        end
    end

    assign DFO_PD_pkt    = buf_pkt_r;
    assign CDO_PD_blkcnt = blkcnt_r;

    // Controller state, packet buffer, round-robin pointer and blocked counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            buf_pkt_r   <= '0;
            rr_ptr_r    <= '0;
            blkcnt_r    <= 16'd0;
            flush_cnt_r <= 4'd0;
        end else if (CFI_PC_flush) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= 4'(FLUSH_CYC);
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (CFI_PC_vld) begin
                        buf_pkt_r <= DFI_PD_pkt;
                        state_r   <= ST_FULL;
                    end else begin
                        state_r   <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (blocked_s) begin
                        if (blkcnt_r != 16'hFFFF) begin
                            blkcnt_r <= blkcnt_r + 16'd1;
                        end else begin
                            blkcnt_r <= blkcnt_r;
                        end
                    end else begin
                        if (dispatch_s) begin
                            rr_ptr_r <= W_RS_IDX'((int'(sel_s) + 1) % N_RS);
                        end else begin
                            rr_ptr_r <= rr_ptr_r;
                        end
                        // Buffer frees this cycle whether dispatched or dropped
                        if (CFI_PC_vld) begin
                            buf_pkt_r <= DFI_PD_pkt;
                            state_r   <= ST_FULL;
                        end else begin
                            state_r   <= ST_EMPTY;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r <= 4'd1) begin
                        flush_cnt_r <= 4'd0;
                        state_r     <= ST_EMPTY;
                    end else begin
                        flush_cnt_r <= flush_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    flush_cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resv_dispatch_arb.sv
// Bench for resv_dispatch_arb: two instances (open masks and class-restricted masks)
// checked every cycle against a behavioural dispatch model, plus directed checks.
module tb_resv_dispatch_arb;

    localparam int W_PKT = 150;
    localparam int FCYC  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W_PKT-1:0] pkt;
    logic             vld;
    logic [3:0]       full;
    logic             flush;

    logic [1:0]       o_rdy, o_clear, o_err;
    logic [3:0]       o_ena [2];
    logic [W_PKT-1:0] o_pkt [2];
    logic [15:0]      o_blk [2];

    int n_assert = 0;
    int n_fail   = 0;

    // model state per instance
    logic             m_valid [2];
    logic [W_PKT-1:0] m_pkt   [2];
    int               m_rr    [2];
    int               m_blk   [2];
    int               m_fl    [2];

    always #5 clk = ~clk;

    resv_dispatch_arb #(.RS_CLASS_MASK(32'hFFFF_FFFF), .FLUSH_CYC(FCYC)) dut (
        .clk(clk), .rst_n(rst_n), .DFI_PD_pkt(pkt), .CFI_PC_vld(vld), .CFO_PC_rdy(o_rdy[0]),
        .CFI_PC_full(full), .CFI_PC_flush(flush), .DFO_PD_pkt(o_pkt[0]), .CFO_PC_ena(o_ena[0]),
        .CFO_PC_clear(o_clear[0]), .CFO_PC_err(o_err[0]), .CDO_PD_blkcnt(o_blk[0]));

    resv_dispatch_arb #(.RS_CLASS_MASK(32'h0102_0101), .FLUSH_CYC(FCYC)) dut_c (
        .clk(clk), .rst_n(rst_n), .DFI_PD_pkt(pkt), .CFI_PC_vld(vld), .CFO_PC_rdy(o_rdy[1]),
        .CFI_PC_full(full), .CFI_PC_flush(flush), .DFO_PD_pkt(o_pkt[1]), .CFO_PC_ena(o_ena[1]),
        .CFO_PC_clear(o_clear[1]), .CFO_PC_err(o_err[1]), .CDO_PD_blkcnt(o_blk[1]));

    function automatic logic [31:0] mask_of(input int i);
        logic [31:0] m;
        m = (i == 0) ? 32'hFFFF_FFFF : 32'h0102_0101;
        return m;
    endfunction

    // 0 = class unroutable, 1 = dispatch to k, 2 = blocked
    function automatic int pick(input int i, output int k);
        logic [31:0] m;
        int cls, any, rs;
        m   = mask_of(i);
        cls = int'(m_pkt[i][5:3]);
        any = 0;
        k   = -1;
        for (int j = 0; j < 4; j++) begin
            rs = (m_rr[i] + j) % 4;
            if (m[8*rs + cls]) begin
                any = 1;
                if (!full[rs] && k < 0) k = rs;
            end
        end
        if (any == 0) return 0;
        if (k >= 0) return 1;
        return 2;
    endfunction

    function automatic logic [W_PKT-1:0] mk_pkt(input int cls, input int sub);
        logic [W_PKT-1:0] p;
        p = W_PKT'({$urandom, $urandom, $urandom, $urandom, $urandom});
        p[5:3] = 3'(cls);
        p[2:0] = 3'(sub);
        return p;
    endfunction

    task automatic check(input string tag, input logic [W_PKT-1:0] obs, input logic [W_PKT-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_pkt[i] = '0; m_rr[i] = 0; m_blk[i] = 0; m_fl[i] = 0;
        end
    endtask

    // settle combinational paths, then compare both instances to the model
    task automatic settle();
        int r, k;
        logic e_rdy, e_err, e_clr;
        logic [3:0] e_ena;
        #1;
        for (int i = 0; i < 2; i++) begin
            e_rdy = 1'b0; e_err = 1'b0; e_clr = 1'b0; e_ena = 4'b0000;
            if (!rst_n) begin
                e_rdy = 1'b1;
            end else if (flush) begin
                e_clr = (m_fl[i] > 0);
            end else if (m_fl[i] > 0) begin
                e_clr = 1'b1;
            end else if (!m_valid[i]) begin
                e_rdy = 1'b1;
            end else begin
                r = pick(i, k);
                if (r == 0) begin e_rdy = 1'b1; e_err = 1'b1; end
                else if (r == 1) begin e_rdy = 1'b1; e_ena = 4'b0001 << k; end
            end
            check($sformatf("rdy%0d", i), W_PKT'(o_rdy[i]), W_PKT'(e_rdy));
            check($sformatf("ena%0d", i), W_PKT'(o_ena[i]), W_PKT'(e_ena));
            check($sformatf("err%0d", i), W_PKT'(o_err[i]), W_PKT'(e_err));
            check($sformatf("clear%0d", i), W_PKT'(o_clear[i]), W_PKT'(e_clr));
            check($sformatf("pkt%0d", i), o_pkt[i], m_pkt[i]);
            check($sformatf("blkcnt%0d", i), W_PKT'(o_blk[i]), W_PKT'(m_blk[i]));
        end
    endtask

    // clock edge: advance model with the inputs present at the edge, return at negedge
    task automatic tick();
        int r, k;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_valid[i] = 1'b0; m_pkt[i] = '0; m_rr[i] = 0; m_blk[i] = 0; m_fl[i] = 0;
            end else if (flush) begin
                m_valid[i] = 1'b0; m_fl[i] = FCYC;
            end else if (m_fl[i] > 0) begin
                m_fl[i] = m_fl[i] - 1;
            end else if (!m_valid[i]) begin
                if (vld) begin m_valid[i] = 1'b1; m_pkt[i] = pkt; end
            end else begin
                r = pick(i, k);
                if (r == 2) begin
                    if (m_blk[i] < 65535) m_blk[i] = m_blk[i] + 1;
                end else begin
                    if (r == 1) m_rr[i] = (k + 1) % 4;
                    m_valid[i] = vld;
                    if (vld) m_pkt[i] = pkt;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    initial begin
        int clr_cnt;
        rst_n = 1'b0; pkt = '0; vld = 1'b0; full = 4'b0000; flush = 1'b0;
        model_reset();
        @(negedge clk);
        settle();
        tick();
        rst_n = 1'b1;

        // reset / idle
        settle();
        check("idle_rdy", W_PKT'(o_rdy[0]), W_PKT'(1'b1));
        check("idle_ena", W_PKT'(o_ena[0]), W_PKT'(4'b0000));
        check("idle_clear", W_PKT'(o_clear[0]), W_PKT'(1'b0));
        check("idle_blk", W_PKT'(o_blk[0]), W_PKT'(16'd0));
        check("idle_pkt", o_pkt[0], W_PKT'(0));
        tick();

        // round-robin, back-to-back
        for (int i = 0; i < 5; i++) begin
            vld = (i < 4);
            pkt = mk_pkt(0, i);
            settle();
            check("rr_ena", W_PKT'(o_ena[0]), W_PKT'((i == 0) ? 4'b0000 : (4'b0001 << (i - 1))));
            check("rr_rdy", W_PKT'(o_rdy[0]), W_PKT'(1'b1));
            tick();
        end

        // class routing on the restricted instance, at two different pointer positions
        for (int n = 0; n < 2; n++) begin
            vld = 1'b1; pkt = mk_pkt(1, 2);
            cycle();
            vld = 1'b0;
            settle();
            check("cls1_ena", W_PKT'(o_ena[1]), W_PKT'(4'b0100));
            tick();
            vld = 1'b1; pkt = mk_pkt(0, n);
            cycle();
            vld = 1'b0;
            cycle();
        end
        vld = 1'b1; pkt = mk_pkt(7, 0);
        cycle();
        vld = 1'b0;
        settle();
        check("cls7_err", W_PKT'(o_err[1]), W_PKT'(1'b1));
        check("cls7_ena", W_PKT'(o_ena[1]), W_PKT'(4'b0000));
        check("cls7_rdy", W_PKT'(o_rdy[1]), W_PKT'(1'b1));
        tick();
        cycle();

        // blocking and release
        vld = 1'b1; pkt = mk_pkt(0, 5); full = 4'b1111;
        cycle();
        vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("blk_rdy", W_PKT'(o_rdy[0]), W_PKT'(1'b0));
            check("blk_ena", W_PKT'(o_ena[0]), W_PKT'(4'b0000));
            tick();
        end
        full = 4'b1101;
        settle();
        check("blk_cnt5", W_PKT'(o_blk[0]), W_PKT'(16'd5));
        check("release_ena", W_PKT'(o_ena[0]), W_PKT'(4'b0010));
        tick();
        full = 4'b0000;
        cycle();

        // flush of a blocked packet
        vld = 1'b1; pkt = mk_pkt(0, 6); full = 4'b1111;
        cycle();
        vld = 1'b0;
        cycle();
        flush = 1'b1;
        settle();
        check("fl_rdy0", W_PKT'(o_rdy[0]), W_PKT'(1'b0));
        check("fl_ena0", W_PKT'(o_ena[0]), W_PKT'(4'b0000));
        tick();
        flush = 1'b0;
        full = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("fl_clear", W_PKT'(o_clear[0]), W_PKT'(1'b1));
            check("fl_rdy", W_PKT'(o_rdy[0]), W_PKT'(1'b0));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            settle();
            check("postfl_rdy", W_PKT'(o_rdy[0]), W_PKT'(1'b1));
            check("postfl_clear", W_PKT'(o_clear[0]), W_PKT'(1'b0));
            check("postfl_ena", W_PKT'(o_ena[0]), W_PKT'(4'b0000));
            tick();
        end

        // second flush during first clear cycle extends clear to three cycles
        flush = 1'b1;
        cycle();
        cycle();
        flush = 1'b0;
        clr_cnt = 1;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (o_clear[0] === 1'b1) clr_cnt++;
            tick();
        end
        check("reflush_len", W_PKT'(clr_cnt), W_PKT'(3));

        // async reset while holding a blocked packet
        vld = 1'b1; pkt = mk_pkt(0, 7); full = 4'b1111;
        cycle();
        vld = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_ena", W_PKT'(o_ena[0]), W_PKT'(4'b0000));
        check("arst_rdy", W_PKT'(o_rdy[0]), W_PKT'(1'b1));
        check("arst_clear", W_PKT'(o_clear[0]), W_PKT'(1'b0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        full = 4'b0000;
        cycle();

        // async reset in the middle of a flush
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        settle();
        #1 rst_n = 1'b0;
        #1;
        check("arst_fl_clear", W_PKT'(o_clear[0]), W_PKT'(1'b0));
        check("arst_fl_rdy", W_PKT'(o_rdy[0]), W_PKT'(1'b1));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            vld   = 1'($urandom_range(0, 3) != 0);
            pkt   = mk_pkt(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            full  = 4'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 1'b0;
        cycle();

        // blocked-counter saturation
        vld = 1'b1; pkt = mk_pkt(0, 1); full = 4'b0000;
        cycle();
        cycle();
        vld = 1'b0; full = 4'b1111;
        for (int i = 0; i < 65600; i++) begin
            cycle();
        end
        settle();
        check("blk_sat", W_PKT'(o_blk[0]), W_PKT'(16'hFFFF));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
